move_sequencer: RTL and testbench



---
 rtl/move_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_move_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// move_sequencer
//   Buffers the cube-solution move stream and hands moves one at a time to
//   the stepper move stage. Each move is presented on next_move with a
//   one-cycle move_start pulse. The sequencer then waits for move_done to
//   fall and rise again, settles for SETTLE_CYCLES, and only then issues the
//   next move.
//
//   Optional feature (macro MOVE_SEQ_COUNT_EN):
//     defined   - moves_done_count counts moves that completed normally,
//                 saturating at 16'hFFFF
//     undefined - no counter is built; moves_done_count is tied to 0
//
// Ports
//   clock, reset_n    system clock, asynchronous active-low reset
//   move_in[3:0]      move code from upstream (2..13 are valid moves)
//   move_valid        move_in valid this cycle
//   move_ready        FIFO can accept a move (not full), combinational
//   run               level; when low, no new move is dequeued
//   flush             one-cycle pulse; empties the FIFO
//   next_move[3:0]    move currently being executed (held between moves)
//   move_start        one-cycle start pulse to the stepper stage
//   move_done         high when all steppers are idle
//   busy              high in every state except IDLE
//   fill              FIFO occupancy
//   moves_done_count  completed-move counter
module move_sequencer #(
    parameter int DEPTH         = 32,
    parameter int BUSY_TIMEOUT  = 1000,
    parameter int SETTLE_CYCLES = 250000
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [3:0]               move_in,
    input  logic                     move_valid,
    output logic                     move_ready,
    input  logic                     run,
    input  logic                     flush,
    output logic [3:0]               next_move,
    output logic                     move_start,
    input  logic                     move_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [15:0]              moves_done_count
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CNT_MAX = (BUSY_TIMEOUT > SETTLE_CYCLES) ? BUSY_TIMEOUT : SETTLE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_SETTLE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    next_move_q, next_move_d;
    logic          move_start_q, move_start_d;
    logic          busy_q, busy_d;
    logic [3:0]    mem_q [DEPTH];

    logic          push;
    logic          pop;
    logic [3:0]    head;
    logic          head_valid;
    logic [CW-1:0] cnt_inc;

    assign move_ready = (fill_q != (AW + 1)'(DEPTH));
    // A push coinciding with flush is dropped.
    assign push       = move_valid && move_ready && !flush;
    assign pop        = (state_q == ST_IDLE) && run && (fill_q != '0) && move_done;
    assign head       = mem_q[rd_ptr_q];
    assign head_valid = (head >= 4'd2) && (head <= 4'd13);
    assign cnt_inc    = cnt_q + CW'(1);

    // Storage has no reset; only pointers and fill define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= move_in;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                fill_d = fill_q + (AW + 1)'(1);
            end else if (pop && !push) begin
                fill_d = fill_q - (AW + 1)'(1);
            end
        end
    end

    // Flush only touches the FIFO; a move already handed to the steppers
    // cannot be cancelled, so the FSM always runs it to completion.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        next_move_d = next_move_q;
        unique case (state_q)
            ST_IDLE: begin
                // Invalid codes are popped and silently discarded.
                if (pop && head_valid) begin
                    next_move_d = head;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // Steppers disabled or in reset never drop move_done.
                if (!move_done) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_DONE;
                end else if (cnt_inc == CW'(BUSY_TIMEOUT)) begin
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT_DONE: begin
                if (move_done) begin
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_inc == CW'(SETTLE_CYCLES)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Registered outputs are derived from the next state.
        move_start_d = (state_d == ST_ISSUE);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            cnt_q        <= '0;
            next_move_q  <= '0;
            move_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
            cnt_q        <= cnt_d;
            next_move_q  <= next_move_d;
            move_start_q <= move_start_d;
            busy_q       <= busy_d;
        end
    end

`ifdef MOVE_SEQ_COUNT_EN
    // Only moves that saw move_done fall and rise are counted; timeouts are not.
    logic        count_inc;
    logic [15:0] count_q, count_d;

    assign count_inc = (state_q == ST_WAIT_DONE) && move_done;

    always_comb begin
        count_d = count_q;
        if (count_inc && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign moves_done_count = count_q;
`else
    assign moves_done_count = '0;
`endif

    assign next_move  = next_move_q;
    assign move_start = move_start_q;
    assign busy       = busy_q;
    assign fill       = fill_q;

endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer
//   Directed bench for move_sequencer with shortened timeout/settle values.
//   A table of FIFO vectors checks fill/ready behaviour with run low; hand
//   written sequences drive a simple stepper model through full moves,
//   invalid codes, the busy timeout, flush mid-move and reset mid-move.
module tb_move_sequencer;

    localparam int DEPTH = 4;
    localparam int BT    = 20;
    localparam int SC    = 6;
    localparam int FW    = $clog2(DEPTH) + 1;

`ifdef MOVE_SEQ_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic          clock;
    logic          reset_n;
    logic [3:0]    move_in;
    logic          move_valid;
    logic          move_ready;
    logic          run;
    logic          flush;
    logic [3:0]    next_move;
    logic          move_start;
    logic          move_done;
    logic          busy;
    logic [FW-1:0] fill;
    logic [15:0]   moves_done_count;

    // Stepper model and its bypass
    logic stepper_en  = 1'b1;
    logic forced_done = 1'b1;
    logic model_done  = 1'b1;
    int   model_stage = 0;
    int   model_tmr   = 0;

    int          vectors     = 0;
    int          miscompares = 0;
    int          unstable    = 0;
    int          exp_count   = 0;
    logic [3:0]  last_start  = 4'd0;
    logic [3:0]  starts[$];

    typedef struct {
        logic       valid;
        logic [3:0] code;
        logic       flsh;
        int         exp_fill;
        logic       exp_ready;
    } vec_t;

    vec_t vecs[9];

    move_sequencer #(
        .DEPTH(DEPTH),
        .BUSY_TIMEOUT(BT),
        .SETTLE_CYCLES(SC)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .move_in(move_in),
        .move_valid(move_valid),
        .move_ready(move_ready),
        .run(run),
        .flush(flush),
        .next_move(next_move),
        .move_start(move_start),
        .move_done(move_done),
        .busy(busy),
        .fill(fill),
        .moves_done_count(moves_done_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    assign move_done = stepper_en ? model_done : forced_done;

    // Stepper drops move_done 3 cycles after the start pulse and raises it 50 cycles later.
    always @(posedge clock) begin
        if (move_start) begin
            model_tmr   <= 3;
            model_stage <= 1;
        end else if (model_stage == 1) begin
            if (model_tmr == 1) begin
                model_done  <= 1'b0;
                model_tmr   <= 50;
                model_stage <= 2;
            end else begin
                model_tmr <= model_tmr - 1;
            end
        end else if (model_stage == 2) begin
            if (model_tmr == 1) begin
                model_done  <= 1'b1;
                model_stage <= 0;
            end else begin
                model_tmr <= model_tmr - 1;
            end
        end
    end

    // Record every issued move and watch that next_move stays put during a move.
    always @(negedge clock) begin
        if (move_start) begin
            starts.push_back(next_move);
            last_start = next_move;
        end else if (busy && (next_move !== last_start)) begin
            unstable++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drives one cycle of stimulus, aligned to the falling edge.
    task automatic applyStimulus(input logic valid, input logic [3:0] code, input logic flsh);
        move_valid = valid;
        move_in    = code;
        flush      = flsh;
        @(negedge clock);
        move_valid = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic waitStarts(input int n, input int budget);
        int i = 0;
        while (starts.size() < n && i < budget) begin
            @(negedge clock);
            i++;
        end
        checkOutput("start_timeout", 32'(starts.size() >= n), 32'd1);
    endtask

    task automatic waitIdle(input int budget);
        int i = 0;
        while ((busy || move_start) && i < budget) begin
            @(negedge clock);
            i++;
        end
        checkOutput("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic waitPulse(input int budget);
        int i = 0;
        while (!move_start && i < budget) begin
            @(negedge clock);
            i++;
        end
        checkOutput("pulse_timeout", 32'(move_start), 32'd1);
    endtask

    function automatic logic [31:0] startAt(input int i);
        if (i < starts.size()) return 32'(starts[i]);
        return 32'hFF;
    endfunction

    initial begin
        int n;

        vecs[0] = '{1'b1, 4'd3,  1'b0, 1, 1'b1};
        vecs[1] = '{1'b1, 4'd4,  1'b0, 2, 1'b1};
        vecs[2] = '{1'b1, 4'd7,  1'b0, 3, 1'b1};
        vecs[3] = '{1'b1, 4'd9,  1'b0, 4, 1'b0};
        vecs[4] = '{1'b1, 4'd10, 1'b0, 4, 1'b0};
        vecs[5] = '{1'b0, 4'd0,  1'b0, 4, 1'b0};
        vecs[6] = '{1'b1, 4'd11, 1'b1, 0, 1'b1};
        vecs[7] = '{1'b1, 4'd2,  1'b0, 1, 1'b1};
        vecs[8] = '{1'b0, 4'd0,  1'b1, 0, 1'b1};

        reset_n    = 1'b0;
        move_in    = 4'd0;
        move_valid = 1'b0;
        run        = 1'b0;
        flush      = 1'b0;
        idle(3);

        checkOutput("rst_next_move", 32'(next_move), 32'd0);
        checkOutput("rst_move_start", 32'(move_start), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_fill", 32'(fill), 32'd0);
        checkOutput("rst_count", 32'(moves_done_count), 32'd0);
        checkOutput("rst_ready", 32'(move_ready), 32'd1);

        reset_n = 1'b1;
        idle(1);

        // FIFO behaviour with run low: fill to DEPTH, overflow, flush
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].code, vecs[i].flsh);
            checkOutput($sformatf("vec%0d_fill", i), 32'(fill), 32'(vecs[i].exp_fill));
            checkOutput($sformatf("vec%0d_ready", i), 32'(move_ready), 32'(vecs[i].exp_ready));
            checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
        end

        // Four moves queued with run low, then run, then flush mid-move
        starts.delete();
        applyStimulus(1'b1, 4'd2, 1'b0);
        applyStimulus(1'b1, 4'd4, 1'b0);
        applyStimulus(1'b1, 4'd6, 1'b0);
        applyStimulus(1'b1, 4'd8, 1'b0);
        checkOutput("q4_fill", 32'(fill), 32'd4);
        checkOutput("q4_ready", 32'(move_ready), 32'd0);
        idle(3);
        checkOutput("q4_no_start", 32'(starts.size()), 32'd0);
        run = 1'b1;
        checkOutput("run_start_early", 32'(move_start), 32'd0);
        idle(1);
        checkOutput("run_start", 32'(move_start), 32'd1);
        checkOutput("run_next_move", 32'(next_move), 32'd2);
        idle(10);
        applyStimulus(1'b0, 4'd0, 1'b1);
        checkOutput("flush_fill", 32'(fill), 32'd0);
        checkOutput("flush_ready", 32'(move_ready), 32'd1);
        checkOutput("flush_busy", 32'(busy), 32'd1);
        waitIdle(200);
        idle(20);
        if (COUNT_EN) exp_count = exp_count + 1;
        checkOutput("flush_starts", 32'(starts.size()), 32'd1);
        checkOutput("flush_count", 32'(moves_done_count), 32'(exp_count));

        // Three normal moves
        starts.delete();
        applyStimulus(1'b1, 4'd2, 1'b0);
        applyStimulus(1'b1, 4'd5, 1'b0);
        applyStimulus(1'b1, 4'd12, 1'b0);
        waitStarts(3, 600);
        waitIdle(300);
        if (COUNT_EN) exp_count = exp_count + 3;
        checkOutput("seq_n", 32'(starts.size()), 32'd3);
        checkOutput("seq_m0", startAt(0), 32'd2);
        checkOutput("seq_m1", startAt(1), 32'd5);
        checkOutput("seq_m2", startAt(2), 32'd12);
        checkOutput("seq_stable", 32'(unstable), 32'd0);
        checkOutput("seq_count", 32'(moves_done_count), 32'(exp_count));

        // Invalid codes are discarded without touching next_move
        starts.delete();
        applyStimulus(1'b1, 4'd0, 1'b0);
        idle(3);
        checkOutput("inv_next_move", 32'(next_move), 32'd12);
        checkOutput("inv_fill", 32'(fill), 32'd0);
        checkOutput("inv_busy", 32'(busy), 32'd0);
        applyStimulus(1'b1, 4'd15, 1'b0);
        applyStimulus(1'b1, 4'd6, 1'b0);
        waitStarts(1, 100);
        waitIdle(200);
        idle(5);
        if (COUNT_EN) exp_count = exp_count + 1;
        checkOutput("inv_n", 32'(starts.size()), 32'd1);
        checkOutput("inv_m0", startAt(0), 32'd6);
        checkOutput("inv_fill_end", 32'(fill), 32'd0);
        checkOutput("inv_count", 32'(moves_done_count), 32'(exp_count));

        // Busy timeout: move_done never falls
        stepper_en  = 1'b0;
        forced_done = 1'b1;
        starts.delete();
        applyStimulus(1'b1, 4'd8, 1'b0);
        waitPulse(20);
        checkOutput("to_next_move", 32'(next_move), 32'd8);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        checkOutput("to_busy_cycles", 32'(n), 32'(BT + SC + 1));
        idle(10);
        checkOutput("to_starts", 32'(starts.size()), 32'd1);
        checkOutput("to_count", 32'(moves_done_count), 32'(exp_count));

        // Reset during WAIT_DONE
        stepper_en = 1'b1;
        idle(60);
        applyStimulus(1'b1, 4'd13, 1'b0);
        waitPulse(20);
        idle(10);
        checkOutput("pre_rst_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_move_start", 32'(move_start), 32'd0);
        checkOutput("mid_rst_next_move", 32'(next_move), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_count", 32'(moves_done_count), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        exp_count = 0;
        starts.delete();
        idle(80);
        checkOutput("post_rst_starts", 32'(starts.size()), 32'd0);
        checkOutput("post_rst_fill", 32'(fill), 32'd0);
        applyStimulus(1'b1, 4'd3, 1'b0);
        waitStarts(1, 20);
        checkOutput("refill_m0", startAt(0), 32'd3);
        waitIdle(200);
        if (COUNT_EN) exp_count = exp_count + 1;
        checkOutput("refill_count", 32'(moves_done_count), 32'(exp_count));
        checkOutput("final_stable", 32'(unstable), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
